seq_alu: RTL

Parametrised, multi-cycle successor to the combinational datapath ALU, with the same 5-bit opcode map.
- Operands are captured through a valid/ready handshake.
- Single-cycle ops are executed in one registered step; MUL and DIV are executed iteratively over WIDTH cycles.
- The result is held as a HI/LO pair until the consumer accepts it.
- Sits between the register-file read ports/Y register and the Z (HI/LO) write-back path.

---
 rtl/seq_alu.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a valid/ready operand handshake and a held
// HI/LO result. It uses the same 5-bit opcode map as the combinational ALU.
// Single-cycle ops complete in one registered step. MUL (radix-2 Booth) and
// DIV (restoring, on magnitudes) iterate one bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept an operation (state is IDLE)
//   opcode     operation select (0..18 legal, 19..31 illegal)
//   a, b       operands (a = Y)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   hi, lo     result pair (mul high word / div remainder / 0, and low word)
//   div0       divide-by-zero flag, qualified by out_valid
//   illegal    illegal-opcode flag, qualified by out_valid
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for in_valid; single-cycle ops resolve on the accept edge
// MUL     | Booth iterations, one multiplier bit per cycle
// DIV     | restoring-divide iterations, one quotient bit per cycle
// DIV_FIX | apply quotient/remainder signs
// DONE    | result held on hi/lo until out_ready

module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_LOAD  = 5'd0;
    localparam logic [4:0] OP_LOADI = 5'd1;
    localparam logic [4:0] OP_STORE = 5'd2;
    localparam logic [4:0] OP_ADD   = 5'd3;
    localparam logic [4:0] OP_SUB   = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_SHR   = 5'd7;
    localparam logic [4:0] OP_SHRA  = 5'd8;
    localparam logic [4:0] OP_SHL   = 5'd9;
    localparam logic [4:0] OP_ROR   = 5'd10;
    localparam logic [4:0] OP_ROL   = 5'd11;
    localparam logic [4:0] OP_ADDI  = 5'd12;
    localparam logic [4:0] OP_ANDI  = 5'd13;
    localparam logic [4:0] OP_ORI   = 5'd14;
    localparam logic [4:0] OP_MUL   = 5'd15;
    localparam logic [4:0] OP_DIV   = 5'd16;
    localparam logic [4:0] OP_NEG   = 5'd17;
    localparam logic [4:0] OP_NOT   = 5'd18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DIV_FIX,
        S_DONE
    } state_t;

    state_t state;

    // Iteration datapath. acc is one bit wider than an operand so the
    // Booth add/subtract of a most-negative multiplicand cannot overflow.
    // In DIV, acc[WIDTH-1:0] holds the partial remainder.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;       // multiplier / dividend, shifted out as it goes
    logic             q_1;      // Booth guard bit
    logic [WIDTH-1:0] op_m;     // multiplicand, or divisor magnitude
    logic [SHW-1:0]   cnt;
    logic             sign_q;
    logic             sign_r;

    assign in_ready = (state == S_IDLE);

    // Single-cycle result computed straight from the inputs on the accept edge.
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_lo;
    logic             op_illegal;

    assign sh         = b[SHW-1:0];
    assign op_illegal = (opcode > OP_NOT);

    always_comb begin
        alu_lo = '0;
        case (opcode)
            OP_LOAD, OP_LOADI, OP_STORE, OP_ADD, OP_ADDI: alu_lo = a + b;
            OP_SUB:          alu_lo = a - b;
            OP_AND, OP_ANDI: alu_lo = a & b;
            OP_OR, OP_ORI:   alu_lo = a | b;
            OP_SHR:          alu_lo = a >> sh;
            OP_SHRA:         alu_lo = $unsigned($signed(a) >>> sh);
            OP_SHL:          alu_lo = a << sh;
            // A shift by WIDTH yields zero, so sh==0 falls out naturally.
            OP_ROR:          alu_lo = (a >> sh) | (a << (WIDTH - int'(sh)));
            OP_ROL:          alu_lo = (a << sh) | (a >> (WIDTH - int'(sh)));
            OP_NEG:          alu_lo = -b;
            OP_NOT:          alu_lo = ~b;
            default:         alu_lo = '0;
        endcase
    end

    // The magnitude of the most negative value is 2^(WIDTH-1). That value
    // is still correct when it is read as unsigned.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // One Booth step: add/sub the multiplicand, then arithmetic-shift the
    // {acc, mq, q_1} chain right by one.
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_mq;

    assign m_ext = {op_m[WIDTH-1], op_m};

    always_comb begin
        booth_sum = acc;
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
    end

    assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_mq  = {booth_sum[0], mq[WIDTH-1:1]};

    // One restoring-divide step. The shifted remainder is always below
    // 2*divisor, so the trial subtract's sign bit alone decides the quotient bit.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_mq;

    assign div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, op_m};
    assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign div_mq    = {mq[WIDTH-2:0], ~div_trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div0      <= 1'b0;
            illegal   <= 1'b0;
            acc       <= '0;
            mq        <= '0;
            q_1       <= 1'b0;
            op_m      <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op_illegal) begin
                            hi        <= '0;
                            lo        <= '0;
                            illegal   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (opcode == OP_MUL) begin
                            acc   <= '0;
                            mq    <= b;
                            q_1   <= 1'b0;
                            op_m  <= a;
                            cnt   <= SHW'(WIDTH - 1);
                            state <= S_MUL;
                        end else if (opcode == OP_DIV) begin
                            if (b == '0) begin
                                hi        <= a;
                                lo        <= '1;
                                div0      <= 1'b1;
                                out_valid <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                acc    <= '0;
                                mq     <= a_mag;
                                op_m   <= b_mag;
                                sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                                sign_r <= a[WIDTH-1];
                                cnt    <= SHW'(WIDTH - 1);
                                state  <= S_DIV;
                            end
                        end else begin
                            hi        <= '0;
                            lo        <= alu_lo;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end

                S_MUL: begin
                    acc <= booth_acc;
                    mq  <= booth_mq;
                    q_1 <= mq[0];
                    if (cnt == '0) begin
                        hi        <= booth_acc[WIDTH-1:0];
                        lo        <= booth_mq;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DIV: begin
                    acc <= {1'b0, div_rem};
                    mq  <= div_mq;
                    if (cnt == '0) begin
                        state <= S_DIV_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Most-negative / -1 gives magnitude 2^(WIDTH-1) with a
                // positive sign, which reads back as a itself.
                S_DIV_FIX: begin
                    lo        <= sign_q ? -mq : mq;
                    hi        <= sign_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        div0      <= 1'b0;
                        illegal   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    div0      <= 1'b0;
                    illegal   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
